// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: shares the VGA adaptor write port between three
// rectangle-drawing requesters (0 = screen loader, 1 = text overlay,
// 2 = animation sprite). Round-robin arbitration, one pixel per clock,
// with pixels outside the screen scanned but never plotted.
module vga_draw_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [3*X_W-1:0]      cmd_x,
  input  logic [3*Y_W-1:0]      cmd_y,
  input  logic [3*X_W-1:0]      cmd_w,
  input  logic [3*Y_W-1:0]      cmd_h,
  input  logic [3*COLOUR_W-1:0] cmd_colour,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic                  busy,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [COLOUR_W-1:0]   vga_colour,
  output logic                  vga_plot
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Coordinates are carried one bit wider than the ports so a rectangle
  // running off the right/bottom edge never wraps back onto the screen.
  localparam logic [X_W:0] X_LIM = X_MAX[X_W:0];
  localparam logic [Y_W:0] Y_LIM = Y_MAX[Y_W:0];
  localparam logic [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};

  state_t state, state_next;

  logic [1:0]          last;
  logic                win_valid;
  logic [1:0]          win_idx;
  logic [2:0]          win_onehot;

  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [X_W-1:0]      sel_w;
  logic [Y_W-1:0]      sel_h;
  logic [COLOUR_W-1:0] sel_colour;
  logic                sel_empty;
  logic [X_W:0]        sel_x_ext;
  logic [Y_W:0]        sel_y_ext;

  logic [X_W:0]        x0;
  logic [X_W:0]        end_x;
  logic [Y_W:0]        end_y;
  logic [X_W:0]        cx;
  logic [Y_W:0]        cy;
  logic [X_W:0]        next_cx;
  logic [Y_W:0]        next_cy;
  logic                last_col;
  logic                last_pixel;

  // Round-robin pick: search starts just after the previous winner.
  always_comb begin
    win_valid = |req;
    win_idx   = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      win_idx = 2'd1;
        else if (req[2]) win_idx = 2'd2;
        else             win_idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      win_idx = 2'd2;
        else if (req[0]) win_idx = 2'd0;
        else             win_idx = 2'd1;
      end
      default: begin
        if (req[0])      win_idx = 2'd0;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd2;
      end
    endcase
  end

  assign win_onehot = 3'b001 << win_idx;

  assign sel_x      = cmd_x[win_idx*X_W +: X_W];
  assign sel_y      = cmd_y[win_idx*Y_W +: Y_W];
  assign sel_w      = cmd_w[win_idx*X_W +: X_W];
  assign sel_h      = cmd_h[win_idx*Y_W +: Y_W];
  assign sel_colour = cmd_colour[win_idx*COLOUR_W +: COLOUR_W];
  assign sel_empty  = (sel_w == '0) || (sel_h == '0);
  assign sel_x_ext  = {1'b0, sel_x};
  assign sel_y_ext  = {1'b0, sel_y};

  // Raster stepping: x is the inner loop, y the outer loop.
  always_comb begin
    last_col   = (cx == end_x);
    last_pixel = last_col && (cy == end_y);
    next_cx    = cx + X_ONE;
    next_cy    = cy;
    if (last_col) begin
      next_cx = x0;
      next_cy = cy + Y_ONE;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decision; empty rectangles skip straight to completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (win_valid) state_next = sel_empty ? DONE : DRAW;
      end
      DRAW: begin
        if (last_pixel) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latching, raster counters and the registered pixel port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant      <= 3'b000;
      done       <= 3'b000;
      last       <= 2'd2;
      x0         <= '0;
      end_x      <= '0;
      end_y      <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 3'b000;
          vga_plot <= 1'b0;
          if (win_valid) begin
            grant <= win_onehot;
            last  <= win_idx;
            x0    <= sel_x_ext;
            cx    <= sel_x_ext;
            cy    <= sel_y_ext;
            end_x <= sel_x_ext + {1'b0, sel_w} - X_ONE;
            end_y <= sel_y_ext + {1'b0, sel_h} - Y_ONE;
            if (sel_empty) begin
              done <= win_onehot;
            end else begin
              vga_x      <= sel_x;
              vga_y      <= sel_y;
              vga_colour <= sel_colour;
              vga_plot   <= (sel_x_ext < X_LIM) && (sel_y_ext < Y_LIM);
            end
          end
        end
        DRAW: begin
          if (last_pixel) begin
            done     <= grant;
            vga_plot <= 1'b0;
          end else begin
            cx       <= next_cx;
            cy       <= next_cy;
            vga_x    <= next_cx[X_W-1:0];
            vga_y    <= next_cy[Y_W-1:0];
            vga_plot <= (next_cx < X_LIM) && (next_cy < Y_LIM);
          end
        end
        default: begin
          grant    <= 3'b000;
          done     <= 3'b000;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == DRAW) || (state == DONE);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: table-driven cycle vectors for a single rectangle
// and three-way contention, followed by hand-written sequences for empty
// rectangles, fairness, clipping and reset during a draw.
module tb_vga_draw_arbiter;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  logic             clock;
  logic             reset;
  logic [2:0]       req;
  logic [3*X_W-1:0] cmd_x;
  logic [3*Y_W-1:0] cmd_y;
  logic [3*X_W-1:0] cmd_w;
  logic [3*Y_W-1:0] cmd_h;
  logic [3*C_W-1:0] cmd_colour;
  logic [2:0]       grant;
  logic [2:0]       done;
  logic             busy;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic             vga_plot;

  int n_checks = 0;
  int n_fails  = 0;

  vga_draw_arbiter dut (
    .clock(clock), .reset(reset), .req(req),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour),
    .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  // 50 MHz-style free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic       plot;
    int         vx;
    int         vy;
    int         vc;
  } vec_t;

  vec_t vecs[18];

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int i, input int x, input int y, input int w,
                         input int h, input int c);
    cmd_x[i*X_W +: X_W]      = X_W'(x);
    cmd_y[i*Y_W +: Y_W]      = Y_W'(y);
    cmd_w[i*X_W +: X_W]      = X_W'(w);
    cmd_h[i*Y_W +: Y_W]      = Y_W'(h);
    cmd_colour[i*C_W +: C_W] = C_W'(c);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic apply_stimulus(input logic [2:0] r);
    req = r;
    @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string tag, input int g, input int d,
                              input int b, input int p);
    check_output({tag, " grant"}, int'(grant), g);
    check_output({tag, " done"},  int'(done), d);
    check_output({tag, " busy"},  int'(busy), b);
    check_output({tag, " plot"},  int'(vga_plot), p);
  endtask

  task automatic check_pixel(input string tag, input int x, input int y, input int c);
    check_output({tag, " vga_x"}, int'(vga_x), x);
    check_output({tag, " vga_y"}, int'(vga_y), y);
    check_output({tag, " colour"}, int'(vga_colour), c);
  endtask

  initial begin
    int px[8];
    int py[8];
    int pp[8];

    reset      = 1'b1;
    req        = 3'b000;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_w      = '0;
    cmd_h      = '0;
    cmd_colour = '0;

    set_cmd(0, 10, 5, 2, 2, 3);
    set_cmd(1, 20, 30, 1, 1, 5);
    set_cmd(2, 40, 50, 1, 1, 6);

    //            req     grant   done    b  p  vx  vy  vc
    vecs[0]  = '{3'b001, 3'b001, 3'b000, 1, 1, 10,  5, 3};
    vecs[1]  = '{3'b001, 3'b001, 3'b000, 1, 1, 11,  5, 3};
    vecs[2]  = '{3'b000, 3'b001, 3'b000, 1, 1, 10,  6, 3};
    vecs[3]  = '{3'b000, 3'b001, 3'b000, 1, 1, 11,  6, 3};
    vecs[4]  = '{3'b000, 3'b001, 3'b001, 1, 0, 11,  6, 3};
    vecs[5]  = '{3'b000, 3'b000, 3'b000, 0, 0, 11,  6, 3};
    vecs[6]  = '{3'b111, 3'b010, 3'b000, 1, 1, 20, 30, 5};
    vecs[7]  = '{3'b111, 3'b010, 3'b010, 1, 0, 20, 30, 5};
    vecs[8]  = '{3'b111, 3'b000, 3'b000, 0, 0, 20, 30, 5};
    vecs[9]  = '{3'b111, 3'b100, 3'b000, 1, 1, 40, 50, 6};
    vecs[10] = '{3'b111, 3'b100, 3'b100, 1, 0, 40, 50, 6};
    vecs[11] = '{3'b111, 3'b000, 3'b000, 0, 0, 40, 50, 6};
    vecs[12] = '{3'b111, 3'b001, 3'b000, 1, 1, 10,  5, 3};
    vecs[13] = '{3'b000, 3'b001, 3'b000, 1, 1, 11,  5, 3};
    vecs[14] = '{3'b000, 3'b001, 3'b000, 1, 1, 10,  6, 3};
    vecs[15] = '{3'b000, 3'b001, 3'b000, 1, 1, 11,  6, 3};
    vecs[16] = '{3'b000, 3'b001, 3'b001, 1, 0, 11,  6, 3};
    vecs[17] = '{3'b000, 3'b000, 3'b000, 0, 0, 11,  6, 3};

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_status("reset", 0, 0, 0, 0);
    check_pixel("reset", 0, 0, 0);
    reset = 1'b0;
    apply_stimulus(3'b000);
    check_status("idle", 0, 0, 0, 0);

    // Single rectangle then three-way contention.
    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i].req);
      check_status(tag, int'(vecs[i].grant), int'(vecs[i].done),
                   int'(vecs[i].busy), int'(vecs[i].plot));
      check_pixel(tag, vecs[i].vx, vecs[i].vy, vecs[i].vc);
    end

    // Empty rectangle: granted and completed in a single cycle, nothing plotted.
    set_cmd(1, 30, 30, 0, 5, 2);
    apply_stimulus(3'b010);
    check_status("zero", 3'b010, 3'b010, 1, 0);
    apply_stimulus(3'b000);
    check_status("zero idle", 0, 0, 0, 0);

    // Fairness: 0 holds req, 2 arrives mid-draw and must be served next.
    apply_stimulus(3'b001);
    check_status("fair g0", 3'b001, 0, 1, 1);
    apply_stimulus(3'b101);
    apply_stimulus(3'b101);
    apply_stimulus(3'b101);
    check_pixel("fair px4", 11, 6, 3);
    apply_stimulus(3'b101);
    check_status("fair d0", 3'b001, 3'b001, 1, 0);
    apply_stimulus(3'b101);
    check_status("fair idle", 0, 0, 0, 0);
    apply_stimulus(3'b101);
    check_status("fair g2", 3'b100, 0, 1, 1);
    check_pixel("fair g2", 40, 50, 6);
    apply_stimulus(3'b101);
    check_status("fair d2", 3'b100, 3'b100, 1, 0);
    apply_stimulus(3'b001);
    apply_stimulus(3'b001);
    check_status("fair g0b", 3'b001, 0, 1, 1);
    for (int i = 0; i < 5; i++) apply_stimulus(3'b000);
    check_status("fair end", 0, 0, 0, 0);

    // Clipping at the bottom-right corner: 8 scan cycles, 2 plotted.
    set_cmd(0, 158, 119, 4, 2, 7);
    px = '{158, 159, 160, 161, 158, 159, 160, 161};
    py = '{119, 119, 119, 119, 120, 120, 120, 120};
    pp = '{1, 1, 0, 0, 0, 0, 0, 0};
    apply_stimulus(3'b001);
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("clip%0d", i);
      if (i > 0) apply_stimulus(3'b000);
      check_output({tag, " plot"}, int'(vga_plot), pp[i]);
      check_output({tag, " vga_x"}, int'(vga_x), px[i]);
      check_output({tag, " vga_y"}, int'(vga_y), py[i]);
      check_output({tag, " busy"}, int'(busy), 1);
    end
    apply_stimulus(3'b000);
    check_status("clip done", 3'b001, 3'b001, 1, 0);
    apply_stimulus(3'b000);
    check_status("clip idle", 0, 0, 0, 0);

    // Reset during the third pixel of a 4x4 draw.
    set_cmd(0, 1, 1, 4, 4, 2);
    apply_stimulus(3'b001);
    apply_stimulus(3'b000);
    apply_stimulus(3'b000);
    check_pixel("rst px3", 3, 1, 2);
    check_status("rst px3", 3'b001, 0, 1, 1);
    #2 reset = 1'b1;
    #1;
    check_status("rst async", 0, 0, 0, 0);
    #2 reset = 1'b0;
    apply_stimulus(3'b011);
    check_status("rst regrant", 3'b001, 0, 1, 1);
    check_pixel("rst regrant", 1, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
